// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter.
//   arbstate  : arbiter FSM state encoding
//   PORT_*    : requester index used for grant / last-grant tracking
//   LAT_DEFAULT : default memory access latency in cycles
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } arbstate;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DBG = 1'b1;

   localparam int LAT_DEFAULT = 2;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational two-requester round-robin picker.
//   req_i[1:0]  : request vector, bit index = port index
//   last_i      : port granted most recently
//   gnt_valid_o : at least one request present
//   gnt_idx_o   : winning port index
module rr_pick
   import mem_arb_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic       gnt_valid_o,
   output logic       gnt_idx_o
);

   assign gnt_valid_o = |req_i;
   // On a tie the port that did not win last time goes; otherwise the lone requester.
   assign gnt_idx_o   = (req_i[0] & req_i[1]) ? ~last_i : req_i[PORT_DBG];

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter (CPU / debug-loader) in front of a single fixed-latency
// memory. One access at a time; round-robin on conflict.
//   clk, reset           : clock, synchronous active-low reset
//   cpu_* / dbg_*        : level-held request ports; *_rd registered read
//                          data, *_done one-cycle completion pulse
//   cpu_stall            : cpu_req & ~cpu_done, combinational
//   mem_*                : memory strobe, write enable, address, data
//
// state  | meaning
// IDLE   | waiting for a request; grant is decided here
// ACCESS | memory access in progress, cnt counts down from LAT-1
// DONE   | winner's done pulses, read data already in its rd register
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int LAT   = LAT_DEFAULT,
   parameter int WIDTH = 32
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             cpu_req,
   input  logic             cpu_we,
   input  logic [WIDTH-1:0] cpu_adr,
   input  logic [WIDTH-1:0] cpu_wd,
   output logic [WIDTH-1:0] cpu_rd,
   output logic             cpu_done,
   output logic             cpu_stall,
   input  logic             dbg_req,
   input  logic             dbg_we,
   input  logic [WIDTH-1:0] dbg_adr,
   input  logic [WIDTH-1:0] dbg_wd,
   output logic [WIDTH-1:0] dbg_rd,
   output logic             dbg_done,
   output logic             mem_en,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_adr,
   output logic [WIDTH-1:0] mem_wd,
   input  logic [WIDTH-1:0] mem_rd
);

   localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [CW-1:0] CNT_START = CW'(LAT - 1);

   arbstate          state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             last_q, last_d;
   logic             win_q, win_d;
   logic             we_q, we_d;
   logic [WIDTH-1:0] adr_q, adr_d;
   logic [WIDTH-1:0] wd_q, wd_d;
   logic [WIDTH-1:0] cpu_rd_q, cpu_rd_d;
   logic [WIDTH-1:0] dbg_rd_q, dbg_rd_d;

   logic gnt_valid;
   logic gnt_idx;
   logic in_access;
   logic first_cycle;

   rr_pick u_rr_pick (
      .req_i       ({dbg_req, cpu_req}),
      .last_i      (last_q),
      .gnt_valid_o (gnt_valid),
      .gnt_idx_o   (gnt_idx)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         last_q   <= PORT_DBG;
         win_q    <= PORT_CPU;
         we_q     <= 1'b0;
         adr_q    <= '0;
         wd_q     <= '0;
         cpu_rd_q <= '0;
         dbg_rd_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
         win_q    <= win_d;
         we_q     <= we_d;
         adr_q    <= adr_d;
         wd_q     <= wd_d;
         cpu_rd_q <= cpu_rd_d;
         dbg_rd_q <= dbg_rd_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      win_d    = win_q;
      we_d     = we_q;
      adr_d    = adr_q;
      wd_d     = wd_q;
      cpu_rd_d = cpu_rd_q;
      dbg_rd_d = dbg_rd_q;
      case (state_q)
         IDLE: begin
            if (gnt_valid) begin
               win_d   = gnt_idx;
               last_d  = gnt_idx;
               we_d    = (gnt_idx == PORT_DBG) ? dbg_we  : cpu_we;
               adr_d   = (gnt_idx == PORT_DBG) ? dbg_adr : cpu_adr;
               wd_d    = (gnt_idx == PORT_DBG) ? dbg_wd  : cpu_wd;
               cnt_d   = CNT_START;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt_q == '0) begin
               if (!we_q) begin
                  if (win_q == PORT_DBG) dbg_rd_d = mem_rd;
                  else                   cpu_rd_d = mem_rd;
               end
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign in_access   = (state_q == ACCESS);
   // Memory is strobed once per access, in the cycle the counter was loaded.
   assign first_cycle = in_access && (cnt_q == CNT_START);

   assign mem_en  = first_cycle;
   assign mem_we  = first_cycle & we_q;
   assign mem_adr = in_access ? adr_q : '0;
   assign mem_wd  = in_access ? wd_q  : '0;

   assign cpu_done  = (state_q == DONE) && (win_q == PORT_CPU);
   assign dbg_done  = (state_q == DONE) && (win_q == PORT_DBG);
   assign cpu_stall = cpu_req & ~cpu_done;

   assign cpu_rd = cpu_rd_q;
   assign dbg_rd = dbg_rd_q;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int LAT = 2;
   localparam int W   = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          cpu_req, cpu_we, dbg_req, dbg_we;
   logic [W-1:0]  cpu_adr, cpu_wd, dbg_adr, dbg_wd;
   logic [W-1:0]  cpu_rd, dbg_rd;
   logic          cpu_done, dbg_done, cpu_stall;
   logic          mem_en, mem_we;
   logic [W-1:0]  mem_adr, mem_wd, mem_rd;

   int n_checks = 0;
   int n_pass   = 0;

   logic [W-1:0]  ref_mem [64];
   logic [W-1:0]  exp_cpu_rd, exp_dbg_rd;
   logic          last_model;

   always #5 clk = ~clk;

   mem_arbiter #(.LAT(LAT), .WIDTH(W)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wd(cpu_wd),
      .cpu_rd(cpu_rd), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_adr(dbg_adr), .dbg_wd(dbg_wd),
      .dbg_rd(dbg_rd), .dbg_done(dbg_done),
      .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd),
      .mem_rd(mem_rd)
   );

   function automatic logic [W-1:0] init_word(int i);
      return (i == 4) ? 32'hDEADBEEF : (32'h5A00_0000 | 32'(i << 8) | 32'(i));
   endfunction

   // Memory model: write on strobe, read data valid only in the LAT-th access cycle.
   logic [W-1:0] mem_arr [64];
   logic [5:0]   acc_idx = '0;
   int           pc = 0;
   logic         mem_init = 1'b0;

   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 64; i++) mem_arr[i] <= init_word(i);
         mem_init <= 1'b1;
      end else if (mem_en === 1'b1 && mem_we === 1'b1) begin
         mem_arr[mem_adr[7:2]] <= mem_wd;
      end
      if (mem_en === 1'b1) begin
         acc_idx <= mem_adr[7:2];
         pc      <= LAT - 1;
      end else if (pc > 0) begin
         pc <= pc - 1;
      end
   end

   assign mem_rd = (pc == 1) ? mem_arr[acc_idx] : 32'hBAD0_BAD0;

   logic [64:0] mem_log [$];
   always @(posedge clk) if (mem_en === 1'b1) mem_log.push_back({mem_we, mem_adr, mem_wd});

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      int en_cyc, done_cyc;
      en_cyc = -1;
      done_cyc = -1;
      reset = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h10; cpu_wd = '0;
      for (int c = 0; c < 2; c++) begin
         tick();
         n_checks++;
         if ({cpu_rd, dbg_rd, cpu_done, dbg_done, mem_en, mem_we, mem_adr, mem_wd} !== '0)
            $display("FAIL reset_outputs cyc%0d: got en=%b we=%b adr=%h wd=%h crd=%h drd=%h cd=%b dd=%b want all 0",
                     c, mem_en, mem_we, mem_adr, mem_wd, cpu_rd, dbg_rd, cpu_done, dbg_done);
         else n_pass++;
      end
      reset = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (mem_en === 1'b1 && en_cyc < 0) en_cyc = c;
         if (cpu_done === 1'b1 && done_cyc < 0) begin
            done_cyc = c;
            cpu_req = 1'b0;
         end
      end
      n_checks++;
      if (en_cyc !== 1) $display("FAIL reset_release_mem_en: got cycle %0d want 1", en_cyc);
      else n_pass++;
      n_checks++;
      if (done_cyc !== LAT + 1) $display("FAIL reset_release_done: got cycle %0d want %0d", done_cyc, LAT + 1);
      else n_pass++;
      exp_cpu_rd = ref_mem[4];
      last_model = PORT_CPU;
   endtask

   task automatic test_cpu_read();
      mem_log.delete();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h10; cpu_wd = 32'h0BAD_F00D;
      tick();
      n_checks++;
      if ({mem_en, mem_we, mem_adr, cpu_stall} !== {1'b1, 1'b0, 32'h10, 1'b1})
         $display("FAIL cpu_read_c1: got en=%b we=%b adr=%h stall=%b want 1 0 00000010 1", mem_en, mem_we, mem_adr, cpu_stall);
      else n_pass++;
      tick();
      n_checks++;
      if ({mem_en, cpu_done, cpu_stall} !== 3'b001)
         $display("FAIL cpu_read_c2: got en=%b done=%b stall=%b want 0 0 1", mem_en, cpu_done, cpu_stall);
      else n_pass++;
      tick();
      exp_cpu_rd = ref_mem[4];
      n_checks++;
      if ({cpu_done, cpu_stall, cpu_rd} !== {1'b1, 1'b0, 32'hDEADBEEF})
         $display("FAIL cpu_read_c3: got done=%b stall=%b rd=%h want 1 0 deadbeef", cpu_done, cpu_stall, cpu_rd);
      else n_pass++;
      cpu_req = 1'b0;
      tick();
      n_checks++;
      if (cpu_done !== 1'b0 || mem_log.size() != 1)
         $display("FAIL cpu_read_pulse: got done=%b strobes=%0d want 0 1", cpu_done, mem_log.size());
      else n_pass++;
      last_model = PORT_CPU;
   endtask

   task automatic test_dbg_write();
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_adr = 32'h20; dbg_wd = 32'h12345678;
      tick();
      n_checks++;
      if ({mem_en, mem_we, mem_adr, mem_wd} !== {1'b1, 1'b1, 32'h20, 32'h12345678})
         $display("FAIL dbg_write_c1: got en=%b we=%b adr=%h wd=%h want 1 1 00000020 12345678", mem_en, mem_we, mem_adr, mem_wd);
      else n_pass++;
      tick();
      n_checks++;
      if ({mem_en, mem_we, dbg_done} !== 3'b000)
         $display("FAIL dbg_write_c2: got en=%b we=%b done=%b want 0 0 0", mem_en, mem_we, dbg_done);
      else n_pass++;
      tick();
      ref_mem[8] = 32'h12345678;
      n_checks++;
      if ({dbg_done, cpu_done, dbg_rd} !== {1'b1, 1'b0, exp_dbg_rd})
         $display("FAIL dbg_write_c3: got dd=%b cd=%b rd=%h want 1 0 %h", dbg_done, cpu_done, dbg_rd, exp_dbg_rd);
      else n_pass++;
      dbg_req = 1'b0; dbg_we = 1'b0;
      tick();
      last_model = PORT_DBG;
   endtask

   task automatic test_contention();
      int   cyc [$];
      logic prt [$];
      logic exp_p;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h30;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_adr = 32'h40;
      for (int c = 1; c <= 16; c++) begin
         tick();
         if (cpu_done === 1'b1 || dbg_done === 1'b1) begin
            cyc.push_back(c);
            prt.push_back(dbg_done);
            if (dbg_done === 1'b1) exp_dbg_rd = ref_mem[16];
            else                   exp_cpu_rd = ref_mem[12];
            n_checks++;
            if (cpu_rd !== exp_cpu_rd || dbg_rd !== exp_dbg_rd)
               $display("FAIL contention_data: got crd=%h drd=%h want %h %h", cpu_rd, dbg_rd, exp_cpu_rd, exp_dbg_rd);
            else n_pass++;
         end
      end
      cpu_req = 1'b0; dbg_req = 1'b0;
      n_checks++;
      if (cyc.size() != 4) $display("FAIL contention_count: got %0d pulses want 4", cyc.size());
      else n_pass++;
      for (int k = 0; k < cyc.size() && k < 4; k++) begin
         exp_p = ~last_model;
         n_checks++;
         if (prt[k] !== exp_p || cyc[k] != 3 + 4 * k)
            $display("FAIL contention_grant%0d: got port=%b cycle=%0d want port=%b cycle=%0d", k, prt[k], cyc[k], exp_p, 3 + 4 * k);
         else n_pass++;
         last_model = exp_p;
      end
      tick();
      tick();
   endtask

   task automatic test_input_change();
      int pulses;
      pulses = 0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h10; cpu_wd = '0;
      tick();
      cpu_adr = 32'h44; cpu_req = 1'b0; cpu_we = 1'b1;
      #1;
      n_checks++;
      if (mem_adr !== 32'h10 || mem_we !== 1'b0)
         $display("FAIL input_change_c1: got adr=%h we=%b want 00000010 0", mem_adr, mem_we);
      else n_pass++;
      tick();
      n_checks++;
      if (mem_adr !== 32'h10) $display("FAIL input_change_c2: got adr=%h want 00000010", mem_adr);
      else n_pass++;
      for (int c = 2; c <= 7; c++) begin
         if (cpu_done === 1'b1) pulses++;
         tick();
      end
      cpu_we = 1'b0;
      exp_cpu_rd = ref_mem[4];
      n_checks++;
      if (pulses != 1 || cpu_rd !== exp_cpu_rd)
         $display("FAIL input_change_done: got pulses=%0d rd=%h want 1 %h", pulses, cpu_rd, exp_cpu_rd);
      else n_pass++;
      last_model = PORT_CPU;
   endtask

   task automatic test_reset_mid();
      int pulses, done_cyc;
      pulses = 0;
      done_cyc = -1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h30;
      tick();
      tick();
      reset = 1'b0; cpu_req = 1'b0;
      tick();
      exp_cpu_rd = '0; exp_dbg_rd = '0; last_model = PORT_DBG;
      n_checks++;
      if ({mem_en, mem_we, cpu_done, cpu_rd} !== '0)
         $display("FAIL reset_mid_outputs: got en=%b we=%b done=%b rd=%h want 0 0 0 0", mem_en, mem_we, cpu_done, cpu_rd);
      else n_pass++;
      reset = 1'b1;
      for (int c = 0; c < 4; c++) begin
         if (cpu_done === 1'b1 || dbg_done === 1'b1) pulses++;
         tick();
      end
      n_checks++;
      if (pulses != 0) $display("FAIL reset_mid_no_done: got %0d pulses want 0", pulses);
      else n_pass++;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h10;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_adr = 32'h40;
      for (int c = 1; c <= 8 && done_cyc < 0; c++) begin
         tick();
         if (cpu_done === 1'b1 || dbg_done === 1'b1) done_cyc = c;
      end
      exp_cpu_rd = ref_mem[4];
      n_checks++;
      if (done_cyc != LAT + 1 || cpu_done !== 1'b1 || cpu_rd !== exp_cpu_rd)
         $display("FAIL reset_mid_recover: got cycle=%0d cd=%b rd=%h want %0d 1 %h", done_cyc, cpu_done, cpu_rd, LAT + 1, exp_cpu_rd);
      else n_pass++;
      cpu_req = 1'b0; dbg_req = 1'b0;
      last_model = PORT_CPU;
      tick();
   endtask

   task automatic test_random();
      for (int r = 0; r < 24; r++) begin
         int          pat, a, lat;
         logic        rc, rdb, exp_w, exp_we, got_port;
         logic [1:0]  got_done;
         logic [W-1:0] exp_adr, exp_wd;
         logic [64:0] entry;
         pat = $urandom_range(1, 3);
         rc  = pat[0];
         rdb = pat[1];
         cpu_we = 1'($urandom_range(0, 1));
         dbg_we = 1'($urandom_range(0, 1));
         a = $urandom_range(0, 63); cpu_adr = 32'(a * 4);
         a = $urandom_range(0, 63); dbg_adr = 32'(a * 4);
         cpu_wd = $urandom;
         dbg_wd = $urandom;
         exp_w   = (rc && rdb) ? ~last_model : rdb;
         exp_we  = exp_w ? dbg_we  : cpu_we;
         exp_adr = exp_w ? dbg_adr : cpu_adr;
         exp_wd  = exp_w ? dbg_wd  : cpu_wd;
         mem_log.delete();
         cpu_req = rc;
         dbg_req = rdb;
         lat = -1;
         got_port = 1'bx;
         got_done = 2'b00;
         for (int c = 1; c <= 8 && lat < 0; c++) begin
            tick();
            if (cpu_done === 1'b1 || dbg_done === 1'b1) begin
               lat = c;
               got_port = dbg_done;
               got_done = {dbg_done, cpu_done};
            end
         end
         cpu_req = 1'b0; dbg_req = 1'b0;
         if (exp_we) ref_mem[exp_adr[7:2]] = exp_wd;
         else if (exp_w) exp_dbg_rd = ref_mem[exp_adr[7:2]];
         else exp_cpu_rd = ref_mem[exp_adr[7:2]];
         last_model = exp_w;
         n_checks++;
         if (lat != LAT + 1 || got_port !== exp_w || got_done !== (exp_w ? 2'b10 : 2'b01))
            $display("FAIL rand%0d_grant: got lat=%0d dones=%b want lat=%0d port=%b", r, lat, got_done, LAT + 1, exp_w);
         else n_pass++;
         n_checks++;
         if (cpu_rd !== exp_cpu_rd || dbg_rd !== exp_dbg_rd)
            $display("FAIL rand%0d_rd: got crd=%h drd=%h want %h %h", r, cpu_rd, dbg_rd, exp_cpu_rd, exp_dbg_rd);
         else n_pass++;
         entry = (mem_log.size() > 0) ? mem_log[0] : 65'h0;
         n_checks++;
         if (mem_log.size() != 1 || entry !== {exp_we, exp_adr, exp_wd})
            $display("FAIL rand%0d_mem: got n=%0d entry=%h want 1 %h", r, mem_log.size(), entry, {exp_we, exp_adr, exp_wd});
         else n_pass++;
         tick();
      end
   endtask

   initial begin
      reset = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = '0; cpu_wd = '0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_adr = '0; dbg_wd = '0;
      for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
      exp_cpu_rd = '0;
      exp_dbg_rd = '0;
      last_model = PORT_DBG;
      test_reset();
      test_cpu_read();
      test_dbg_write();
      test_contention();
      test_input_change();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
      $fatal(1);
   end

endmodule
